// File: rtl/sort_actuator_sched_pkg.sv
// Shared types for the sorting-gate scheduler: class/LED codes, FSM states,
// and the timestamped queue entry.
package sort_pkg;

    localparam int unsigned TIMEBASE_W = 32;

    typedef logic [TIMEBASE_W-1:0] stamp_t;
    typedef logic [1:0]            cls_t;

    localparam cls_t CLS_NONE  = 2'd0;
    localparam cls_t CLS_LARGE = 2'd1;
    localparam cls_t CLS_MID   = 2'd2;
    localparam cls_t CLS_SMALL = 2'd3;

    localparam logic [3:0] LED_NONE  = 4'b0000;
    localparam logic [3:0] LED_LARGE = 4'b0001;
    localparam logic [3:0] LED_MID   = 4'b0010;
    localparam logic [3:0] LED_SMALL = 4'b0100;

    typedef enum logic [1:0] {
        V_IDLE,
        V_COLLECT,
        V_DECIDE
    } vote_state_t;

    typedef enum logic [1:0] {
        O_IDLE,
        O_PULSE,
        O_GAP
    } out_state_t;

    typedef struct packed {
        cls_t   cls;
        stamp_t stamp;
    } entry_t;

    function automatic logic [3:0] led_code(input cls_t c);
        case (c)
            CLS_LARGE: return LED_LARGE;
            CLS_MID:   return LED_MID;
            CLS_SMALL: return LED_SMALL;
            default:   return LED_NONE;
        endcase
    endfunction

endpackage

// File: rtl/sort_actuator_sched_if.sv
// Vision/key inputs and gate/status outputs of the sorting scheduler.
interface sort_actuator_sched_if #(
    parameter int unsigned QDEPTH = 4
);
    localparam int unsigned CW = $clog2(QDEPTH) + 1;

    logic          frame_done;
    logic [10:0]   answer;
    logic          sort_req;
    logic          out1;
    logic          out2;
    logic          out3;
    logic [3:0]    led;
    logic          busy;
    logic [CW-1:0] q_count;
    logic          ovf;

    modport master (
        output frame_done, answer, sort_req,
        input  out1, out2, out3, led, busy, q_count, ovf
    );

    modport slave (
        input  frame_done, answer, sort_req,
        output out1, out2, out3, led, busy, q_count, ovf
    );

endinterface

// File: rtl/sort_actuator_sched_fifo.sv
// Circular queue of pending timestamped decisions; a push into a full queue
// is dropped even when a pop happens in the same cycle.
module sort_pending_fifo
    import sort_pkg::*;
#(
    parameter int unsigned QDEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  entry_t                   push_data,
    input  logic                     pop,
    output entry_t                   head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(QDEPTH):0]  count
);
    localparam int unsigned AW    = $clog2(QDEPTH);
    localparam logic [AW:0] DEPTH = (AW+1)'(QDEPTH);
    localparam logic [AW:0] ONE   = (AW+1)'(1);

    entry_t        mem [QDEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == DEPTH);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/sort_actuator_sched.sv
// Votes the object class over several frames, queues the timestamped decision
// and fires the matching sorting gate once the object has travelled far enough.
module sort_actuator_sched
    import sort_pkg::*;
#(
    parameter int unsigned TH_SMALL    = 5,
    parameter int unsigned TH_MID      = 30,
    parameter int unsigned VOTE_FRAMES = 5,
    parameter int unsigned DELAY_CYC   = 50_000_000,
    parameter int unsigned PULSE_CYC   = 5_000_000,
    parameter int unsigned GAP_CYC     = 1_000_000,
    parameter int unsigned QDEPTH      = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sort_actuator_sched_if.slave bus
);
    localparam int unsigned CW         = $clog2(QDEPTH) + 1;
    localparam logic [10:0] TH_S       = 11'(TH_SMALL);
    localparam logic [10:0] TH_M       = 11'(TH_MID);
    localparam logic [3:0]  VF         = 4'(VOTE_FRAMES);
    localparam stamp_t      DELAY      = stamp_t'(DELAY_CYC);
    localparam stamp_t      PULSE_LAST = stamp_t'(PULSE_CYC - 1);
    localparam stamp_t      GAP_LAST   = (GAP_CYC == 0) ? '0 : stamp_t'(GAP_CYC - 1);
    localparam stamp_t      ONE        = stamp_t'(1);

    stamp_t now;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            now <= '0;
        end else begin
            now <= now + ONE;
        end
    end

    cls_t frame_cls;

    always_comb begin
        if (bus.answer <= TH_S) begin
            frame_cls = CLS_SMALL;
        end else if (bus.answer <= TH_M) begin
            frame_cls = CLS_MID;
        end else begin
            frame_cls = CLS_LARGE;
        end
    end

    vote_state_t v_state;
    logic [3:0]  c1;
    logic [3:0]  c2;
    logic [3:0]  c3;
    logic [3:0]  fcnt;
    logic [3:0]  led_r;
    logic        ovf_r;
    cls_t        win;

    // Strict comparisons give ties to the lower class number.
    always_comb begin
        win = CLS_LARGE;
        if (c2 > c1) begin
            win = CLS_MID;
        end
        if ((c3 > c1) && (c3 > c2)) begin
            win = CLS_SMALL;
        end
    end

    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    entry_t        push_data;
    entry_t        head;
    logic [CW-1:0] count;

    always_comb begin
        push_data       = '0;
        push_data.cls   = win;
        push_data.stamp = now;
    end

    assign push = (v_state == V_DECIDE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_state <= V_IDLE;
            c1      <= '0;
            c2      <= '0;
            c3      <= '0;
            fcnt    <= '0;
            led_r   <= LED_NONE;
            ovf_r   <= 1'b0;
        end else begin
            case (v_state)
                V_IDLE: begin
                    if (bus.sort_req) begin
                        c1      <= '0;
                        c2      <= '0;
                        c3      <= '0;
                        fcnt    <= '0;
                        v_state <= V_COLLECT;
                    end
                end
                V_COLLECT: begin
                    if (bus.frame_done) begin
                        case (frame_cls)
                            CLS_LARGE: c1 <= c1 + 4'd1;
                            CLS_MID:   c2 <= c2 + 4'd1;
                            default:   c3 <= c3 + 4'd1;
                        endcase
                        fcnt <= fcnt + 4'd1;
                        if (fcnt + 4'd1 == VF) begin
                            v_state <= V_DECIDE;
                        end
                    end
                end
                V_DECIDE: begin
                    led_r <= led_code(win);
                    if (full) begin
                        ovf_r <= 1'b1;
                    end
                    v_state <= V_IDLE;
                end
                default: v_state <= V_IDLE;
            endcase
        end
    end

    sort_pending_fifo #(
        .QDEPTH(QDEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    out_state_t o_state;
    stamp_t     o_cnt;
    logic       out1_r;
    logic       out2_r;
    logic       out3_r;
    logic       due;
    logic       ready;
    logic       launch;

    // Modulo-2^32 age keeps the due test correct across timebase wrap.
    assign due = ((now - head.stamp) >= DELAY);

    // The last GAP cycle doubles as the launch slot, so back-to-back pulses
    // are separated by exactly GAP_CYC low cycles.
    always_comb begin
        ready = 1'b0;
        case (o_state)
            O_IDLE:  ready = 1'b1;
            O_PULSE: ready = (o_cnt == '0) && (GAP_CYC == 0);
            O_GAP:   ready = (o_cnt == '0);
            default: ready = 1'b1;
        endcase
        launch = ready && !empty && due;
    end

    assign pop = launch;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_state <= O_IDLE;
            o_cnt   <= '0;
            out1_r  <= 1'b0;
            out2_r  <= 1'b0;
            out3_r  <= 1'b0;
        end else if (launch) begin
            o_state <= O_PULSE;
            o_cnt   <= PULSE_LAST;
            out1_r  <= (head.cls == CLS_LARGE);
            out2_r  <= (head.cls == CLS_MID);
            out3_r  <= (head.cls == CLS_SMALL);
        end else begin
            case (o_state)
                O_PULSE: begin
                    if (o_cnt == '0) begin
                        out1_r <= 1'b0;
                        out2_r <= 1'b0;
                        out3_r <= 1'b0;
                        if (GAP_CYC == 0) begin
                            o_state <= O_IDLE;
                        end else begin
                            o_state <= O_GAP;
                            o_cnt   <= GAP_LAST;
                        end
                    end else begin
                        o_cnt <= o_cnt - ONE;
                    end
                end
                O_GAP: begin
                    if (o_cnt == '0) begin
                        o_state <= O_IDLE;
                    end else begin
                        o_cnt <= o_cnt - ONE;
                    end
                end
                default: o_state <= O_IDLE;
            endcase
        end
    end

    assign bus.out1    = out1_r;
    assign bus.out2    = out2_r;
    assign bus.out3    = out3_r;
    assign bus.led     = led_r;
    assign bus.ovf     = ovf_r;
    assign bus.busy    = (v_state != V_IDLE);
    assign bus.q_count = count;

endmodule

// File: tb/tb_sort_actuator_sched.sv
// Self-checking bench: a schedule model predicts every gate pulse, queue
// occupancy, LED and overflow state cycle by cycle.
module tb_sort_actuator_sched;

    localparam int DELAY = 100;
    localparam int PULSE = 10;
    localparam int GAP   = 4;
    localparam int QD    = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #10 clk = ~clk;

    sort_actuator_sched_if #(.QDEPTH(QD)) bus ();
    sort_actuator_sched_if #(.QDEPTH(QD)) bus1 ();
    sort_actuator_sched_if #(.QDEPTH(QD)) bus2 ();

    sort_actuator_sched #(
        .TH_SMALL(5), .TH_MID(30), .VOTE_FRAMES(3), .DELAY_CYC(DELAY),
        .PULSE_CYC(PULSE), .GAP_CYC(GAP), .QDEPTH(QD)
    ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    sort_actuator_sched #(
        .TH_SMALL(5), .TH_MID(30), .VOTE_FRAMES(1), .DELAY_CYC(DELAY),
        .PULSE_CYC(PULSE), .GAP_CYC(GAP), .QDEPTH(QD)
    ) dut_v1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    sort_actuator_sched #(
        .TH_SMALL(5), .TH_MID(30), .VOTE_FRAMES(2), .DELAY_CYC(DELAY),
        .PULSE_CYC(PULSE), .GAP_CYC(GAP), .QDEPTH(QD)
    ) dut_v2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Model: accepted decisions with decide edge D and pulse start edge S.
    int         ent_cls[$];
    int         ent_d[$];
    int         ent_s[$];
    int         last_s = -1000;
    logic [3:0] m_led  = 4'b0000;
    logic       m_ovf  = 1'b0;
    int         vote_ans[16];

    function automatic int classify(input int a);
        if (a <= 5) return 3;
        if (a <= 30) return 2;
        return 1;
    endfunction

    function automatic logic [3:0] led_of(input int c);
        logic [3:0] v;
        v = 4'b0001;
        return v << (c - 1);
    endfunction

    function automatic int vote_winner(input int n);
        int cnt[4];
        int best;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        for (int i = 0; i < n; i++) cnt[classify(vote_ans[i])]++;
        best = 1;
        for (int c = 2; c <= 3; c++) if (cnt[c] > cnt[best]) best = c;
        return best;
    endfunction

    function automatic int rand_answer();
        case ($urandom_range(0, 3))
            0:       return int'($urandom_range(0, 5));
            1:       return int'($urandom_range(6, 30));
            2:       return int'($urandom_range(31, 2047));
            default: begin
                int edges[6];
                edges = '{0, 5, 6, 30, 31, 2047};
                return edges[$urandom_range(0, 5)];
            end
        endcase
    endfunction

    function automatic void model_decide(input int cls, input int d);
        int occ;
        int s;
        occ = 0;
        foreach (ent_s[k]) if (ent_s[k] >= d) occ++;
        m_led = led_of(cls);
        if (occ < QD) begin
            s = d + DELAY;
            if (last_s + PULSE + GAP > s) s = last_s + PULSE + GAP;
            ent_cls.push_back(cls);
            ent_d.push_back(d);
            ent_s.push_back(s);
            last_s = s;
        end else begin
            m_ovf = 1'b1;
        end
    endfunction

    function automatic void model_reset();
        ent_cls.delete();
        ent_d.delete();
        ent_s.delete();
        last_s = -1000;
        m_led  = 4'b0000;
        m_ovf  = 1'b0;
    endfunction

    task automatic tick_and_check();
        logic [2:0] exp_out;
        logic [2:0] got_out;
        int         qc;
        @(negedge clk);
        exp_out = '0;
        qc      = 0;
        foreach (ent_cls[k]) begin
            if (ent_s[k] <= cyc && cyc < ent_s[k] + PULSE) exp_out[ent_cls[k] - 1] = 1'b1;
            if (ent_d[k] <= cyc && ent_s[k] > cyc) qc++;
        end
        got_out = {bus.out3, bus.out2, bus.out1};
        checks++;
        if (got_out !== exp_out) begin
            errors++;
            $display("FAIL gates cyc=%0d out3..1=%b expected=%b", cyc, got_out, exp_out);
        end
        checks++;
        if (bus.q_count !== 2'(qc)) begin
            errors++;
            $display("FAIL q_count cyc=%0d got=%0d expected=%0d", cyc, bus.q_count, qc);
        end
        checks++;
        if (bus.led !== m_led) begin
            errors++;
            $display("FAIL led cyc=%0d got=%b expected=%b", cyc, bus.led, m_led);
        end
        checks++;
        if (bus.ovf !== m_ovf) begin
            errors++;
            $display("FAIL ovf cyc=%0d got=%b expected=%b", cyc, bus.ovf, m_ovf);
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) tick_and_check();
    endtask

    task automatic issue(input int n, input bit poke);
        bus.sort_req = 1'b1;
        tick_and_check();
        bus.sort_req = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_collect cyc=%0d got=%b expected=1", cyc, bus.busy);
        end
        for (int i = 0; i < n; i++) begin
            bus.frame_done = 1'b1;
            bus.answer     = 11'(vote_ans[i]);
            if (poke && i == 1) bus.sort_req = 1'b1;
            tick_and_check();
            bus.sort_req = 1'b0;
            checks++;
            if (bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL busy_frame cyc=%0d got=%b expected=1", cyc, bus.busy);
            end
        end
        bus.frame_done = 1'b0;
        model_decide(vote_winner(n), cyc + 1);
        tick_and_check();
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_idle cyc=%0d got=%b expected=0", cyc, bus.busy);
        end
    endtask

    task automatic measure(input int ncyc, output int rise, output int h1, output int h2,
                           output int h3, output int gap_low);
        bit seen;
        bit fell;
        int low_run;
        rise = -1; h1 = 0; h2 = 0; h3 = 0; gap_low = -1;
        seen = 1'b0; fell = 1'b0; low_run = 0;
        repeat (ncyc) begin
            tick_and_check();
            if (bus.out1) h1++;
            if (bus.out2) h2++;
            if (bus.out3) h3++;
            if (bus.out1 || bus.out2 || bus.out3) begin
                if (rise < 0) rise = cyc;
                if (fell && gap_low < 0) gap_low = low_run;
                seen = 1'b1;
            end else if (seen) begin
                fell = 1'b1;
                low_run++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick_and_check();
        checks++;
        if (bus.busy !== 1'b0 || bus1.busy !== 1'b0 || bus2.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got=%b%b%b expected=000", bus.busy, bus1.busy, bus2.busy);
        end
        checks++;
        if (bus1.led !== 4'b0000 || bus2.led !== 4'b0000) begin
            errors++;
            $display("FAIL reset_led got=%b/%b expected=0000", bus1.led, bus2.led);
        end
        rst_n = 1'b1;
        tick_and_check();
    endtask

    task automatic test_single(input int a0, input int a1, input int a2, input int gate);
        int d, rise, h1, h2, h3, g;
        int hs[3];
        vote_ans[0] = a0; vote_ans[1] = a1; vote_ans[2] = a2;
        issue(3, 1'b0);
        d = cyc;
        measure(120, rise, h1, h2, h3, g);
        hs = '{h1, h2, h3};
        checks++;
        if (rise - d !== DELAY) begin
            errors++;
            $display("FAIL pulse_delay got=%0d expected=%0d", rise - d, DELAY);
        end
        for (int k = 1; k <= 3; k++) begin
            checks++;
            if (hs[k-1] !== ((k == gate) ? PULSE : 0)) begin
                errors++;
                $display("FAIL pulse_width gate=%0d got=%0d expected=%0d", k, hs[k-1],
                         (k == gate) ? PULSE : 0);
            end
        end
    endtask

    task automatic test_vote1();
        int a;
        for (int i = 0; i < 6; i++) begin
            a = (i == 0) ? 31 : (i == 1) ? 5 : rand_answer();
            bus1.sort_req = 1'b1;
            tick_and_check();
            bus1.sort_req   = 1'b0;
            bus1.frame_done = 1'b1;
            bus1.answer     = 11'(a);
            tick_and_check();
            bus1.frame_done = 1'b0;
            tick_and_check();
            checks++;
            if (bus1.led !== led_of(classify(a))) begin
                errors++;
                $display("FAIL vote1_led answer=%0d got=%b expected=%b", a, bus1.led,
                         led_of(classify(a)));
            end
        end
    endtask

    task automatic test_tie();
        int pa[4];
        int pb[4];
        int a, b;
        pa = '{3, 40, 10, 40};
        pb = '{40, 3, 3, 10};
        for (int i = 0; i < 8; i++) begin
            a = (i < 4) ? pa[i] : rand_answer();
            b = (i < 4) ? pb[i] : rand_answer();
            vote_ans[0] = a; vote_ans[1] = b;
            bus2.sort_req = 1'b1;
            tick_and_check();
            bus2.sort_req   = 1'b0;
            bus2.frame_done = 1'b1;
            bus2.answer     = 11'(a);
            tick_and_check();
            bus2.answer = 11'(b);
            tick_and_check();
            bus2.frame_done = 1'b0;
            tick_and_check();
            checks++;
            if (bus2.led !== led_of(vote_winner(2))) begin
                errors++;
                $display("FAIL tie_led answers=%0d,%0d got=%b expected=%b", a, b, bus2.led,
                         led_of(vote_winner(2)));
            end
        end
    endtask

    task automatic test_back_to_back();
        int t0, rise, h1, h2, h3, g;
        t0 = cyc;
        for (int k = 0; k < 3; k++) begin
            wait_until(t0 + 10 * k);
            for (int i = 0; i < 3; i++) vote_ans[i] = rand_answer();
            issue(3, 1'b0);
        end
        checks++;
        if (bus.ovf !== 1'b1 || bus.q_count !== 2'd2) begin
            errors++;
            $display("FAIL overflow got ovf=%b q=%0d expected ovf=1 q=2", bus.ovf, bus.q_count);
        end
        measure(150, rise, h1, h2, h3, g);
        checks++;
        if (g !== GAP) begin
            errors++;
            $display("FAIL gap_low got=%0d expected=%0d", g, GAP);
        end
        checks++;
        if (h1 + h2 + h3 !== 2 * PULSE) begin
            errors++;
            $display("FAIL b2b_high got=%0d expected=%0d", h1 + h2 + h3, 2 * PULSE);
        end
        checks++;
        if (bus.ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky got=%b expected=1", bus.ovf);
        end
    endtask

    task automatic test_ignore_popush();
        int sa, rise, h1, h2, h3, g;
        for (int i = 0; i < 3; i++) vote_ans[i] = rand_answer();
        issue(3, 1'b1);
        sa = cyc + DELAY;
        wait_until(sa - 5);
        checks++;
        if (bus.q_count !== 2'd1) begin
            errors++;
            $display("FAIL pre_popush q_count got=%0d expected=1", bus.q_count);
        end
        for (int i = 0; i < 3; i++) vote_ans[i] = rand_answer();
        issue(3, 1'b0);
        checks++;
        if (bus.q_count !== 2'd1 || !(bus.out1 || bus.out2 || bus.out3)) begin
            errors++;
            $display("FAIL popush got q=%0d gates=%b%b%b expected q=1 one gate", bus.q_count,
                     bus.out3, bus.out2, bus.out1);
        end
        measure(130, rise, h1, h2, h3, g);
    endtask

    task automatic test_wrap();
        int d, rise, h1, h2, h3, g;
        force dut.now = 32'hFFFF_FFC0;
        tick_and_check();
        release dut.now;
        for (int i = 0; i < 3; i++) vote_ans[i] = rand_answer();
        issue(3, 1'b0);
        d = cyc;
        measure(120, rise, h1, h2, h3, g);
        checks++;
        if (rise - d !== DELAY || h1 + h2 + h3 !== PULSE) begin
            errors++;
            $display("FAIL wrap got delay=%0d high=%0d expected delay=%0d high=%0d", rise - d,
                     h1 + h2 + h3, DELAY, PULSE);
        end
    endtask

    task automatic test_random();
        int rise, h1, h2, h3, g;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 3; i++) vote_ans[i] = rand_answer();
            issue(3, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 70)) tick_and_check();
        end
        measure(300, rise, h1, h2, h3, g);
    endtask

    task automatic test_reset_mid_pulse();
        int d;
        for (int i = 0; i < 3; i++) vote_ans[i] = rand_answer();
        issue(3, 1'b0);
        d = cyc;
        for (int i = 0; i < 3; i++) vote_ans[i] = rand_answer();
        issue(3, 1'b0);
        wait_until(d + DELAY + 3);
        rst_n = 1'b0;
        model_reset();
        tick_and_check();
        checks++;
        if ({bus.out3, bus.out2, bus.out1} !== 3'b000 || bus.q_count !== 2'd0 ||
            bus.led !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid got gates=%b%b%b q=%0d led=%b expected 000/0/0000",
                     bus.out3, bus.out2, bus.out1, bus.q_count, bus.led);
        end
        rst_n = 1'b1;
        repeat (3) tick_and_check();
    endtask

    initial begin
        bus.frame_done  = 1'b0; bus.answer  = '0; bus.sort_req  = 1'b0;
        bus1.frame_done = 1'b0; bus1.answer = '0; bus1.sort_req = 1'b0;
        bus2.frame_done = 1'b0; bus2.answer = '0; bus2.sort_req = 1'b0;
        @(negedge clk);
        test_reset();
        test_single(40, 40, 3, 1);
        test_single(5, 6, 30, 2);
        test_vote1();
        test_tie();
        test_back_to_back();
        test_ignore_popush();
        test_wrap();
        test_random();
        test_reset_mid_pulse();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
